// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an architectural {Z,C,S,O} flags register.
// Define ALU_CARRY_CHAIN_EN to turn modes 0/1 into add-with-carry / subtract-with-borrow.
module alu_pipe #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       mode,
    input  logic             flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic [3:0]       flags_q
);

    localparam int M = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       mode_q, mode_d;
    logic             fwe_q, fwe_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_out_q, flags_out_d;
    logic [3:0]       arch_flags_q, arch_flags_d;

    logic             s1_adv, accept;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    function automatic logic ovf_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[M] == y[M]) && (r[M] != x[M]);
    endfunction

    function automatic logic ovf_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[M] != y[M]) && (r[M] != x[M]);
    endfunction

    // Datapath operates on stage-1 contents and the live flags register.
    always_comb begin
        logic [WIDTH:0]     sum;
        logic [WIDTH:0]     sh;
        logic [2*WIDTH-1:0] dbl;
        logic [SHW-1:0]     s;
        logic               c, o, add_ci, sub_ci;
        s   = a_q[SHW-1:0];
        sum = '0;
        sh  = '0;
        dbl = '0;
        c   = arch_flags_q[2];
        o   = 1'b0;
        alu_res = '0;
`ifdef ALU_CARRY_CHAIN_EN
        add_ci = arch_flags_q[2];
        sub_ci = arch_flags_q[2];
`else
        add_ci = 1'b0;
        sub_ci = 1'b1;
`endif
        // Subtraction is x + ~y + 1, so carry-out doubles as "no borrow".
        case (mode_q)
            4'd0: begin sum = add_c(a_q, b_q, add_ci);  alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_add(a_q, b_q, alu_res); end
            4'd1: begin sum = add_c(a_q, ~b_q, sub_ci); alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_sub(a_q, b_q, alu_res); end
            4'd2: alu_res = a_q;
            4'd3: alu_res = b_q;
            4'd4: alu_res = a_q & b_q;
            4'd5: alu_res = a_q | b_q;
            4'd6: alu_res = a_q ^ b_q;
            4'd7: begin sum = add_c(b_q, ~a_q, 1'b1);   alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_sub(b_q, a_q, alu_res); end
            4'd8: begin sum = add_c(b_q, ONE, 1'b0);    alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_add(b_q, ONE, alu_res); end
            4'd9: begin sum = add_c(b_q, ~ONE, 1'b1);   alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_sub(b_q, ONE, alu_res); end
            4'd10: begin dbl = {b_q, b_q} << s; alu_res = dbl[2*WIDTH-1:WIDTH]; end
            4'd11: begin dbl = {b_q, b_q} >> s; alu_res = dbl[M:0]; end
            4'd12: begin
                sh = {1'b0, b_q} << s;
                alu_res = sh[M:0];
                if (s != '0) c = sh[WIDTH];
            end
            4'd13: begin
                sh = {b_q, 1'b0} >> s;
                alu_res = sh[WIDTH:1];
                if (s != '0) c = sh[0];
            end
            4'd14: begin
                sh = $unsigned($signed({b_q, 1'b0}) >>> s);
                alu_res = sh[WIDTH:1];
                if (s != '0) c = sh[0];
            end
            4'd15: begin sum = add_c(ZERO, ~b_q, 1'b1); alu_res = sum[M:0]; c = sum[WIDTH]; o = ovf_sub(ZERO, b_q, alu_res); end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res == '0, c, alu_res[M], o};
    end

    always_comb begin
        s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s1_adv;
        accept   = in_valid && in_ready;

        s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        a_d    = accept ? op_a    : a_q;
        b_d    = accept ? op_b    : b_q;
        mode_d = accept ? mode    : mode_q;
        fwe_d  = accept ? flag_we : fwe_q;

        out_valid_d  = s1_adv ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        result_d     = s1_adv ? alu_res   : result_q;
        flags_out_d  = s1_adv ? alu_flags : flags_out_q;
        // Commit on the stage-2 entry edge so the next op already sees new flags.
        arch_flags_d = (s1_adv && fwe_q) ? alu_flags : arch_flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            fwe_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_out_q  <= '0;
            arch_flags_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            fwe_q        <= fwe_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            flags_out_q  <= flags_out_d;
            arch_flags_q <= arch_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;
    assign flags_q   = arch_flags_q;

endmodule
